muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have these ports:
  - clock    in  1   sole clock, rising edge.
  - reset    in  1   asynchronous, active-low reset.
  - start    in  1   request pulse from the main control FSM; sampled only in IDLE.
  - op       in  1   0 = MULT, 1 = DIV; sampled with start.
  - a        in  32  operand A (rs), signed two's complement; sampled with start.
  - b        in  32  operand B (rt), signed two's complement; sampled with start.
  - busy     out 1   high while an operation is in progress (any state except IDLE).
  - done     out 1   single-cycle completion pulse.
  - div0     out 1   divide-by-zero flag, valid while done is high.
  - hi       out 32  HI result register.
  - lo       out 32  LO result register.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low, with ports named clock and reset.

Function
REQ-003 The state machine SHALL have the states IDLE, CALC, FIX and DONE; every output SHALL be registered.
REQ-004 In IDLE with start=1 at edge E0, the block SHALL latch op, the magnitudes |a| and |b|, and the sign bits, clear the 6-bit iteration counter, and enter CALC.
REQ-005 In CALC, MULT SHALL perform one shift-add step per cycle on the 64-bit accumulator {hi_acc, lo_acc}; DIV SHALL perform one restoring shift-subtract step per cycle.
REQ-006 After exactly 32 CALC cycles (edges E1..E32), the block SHALL enter FIX.
REQ-007 In FIX at edge E33, the block SHALL apply the sign correction, update hi/lo, set done=1 and enter DONE.
REQ-008 In DONE, done SHALL be high for exactly one cycle; at E34 the block SHALL clear done and div0 and return to IDLE.
REQ-009 MULT SHALL produce the full 64-bit signed product: hi = bits 63:32 and lo = bits 31:0.
REQ-010 DIV SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the sign of a.
REQ-011 For a=0x80000000, b=0xFFFFFFFF, DIV SHALL give lo=0x80000000 and hi=0x00000000 with no flag.
REQ-012 start SHALL be ignored while busy=1; no queuing.
REQ-013 hi and lo SHALL change only at the FIX edge (or as stated under Reset) and SHALL hold between operations.
REQ-014 An operand of zero in MULT SHALL still take the full 33-cycle latency; there SHALL be no early termination.

Reset
REQ-015 While reset=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0 and clear all internal accumulators, including when the reset arrives mid-operation.
REQ-016 After reset deasserts, the first start sampled in IDLE SHALL begin a fresh operation; no partial result from an aborted operation SHALL become visible.

Configuration
REQ-017 With MULDIV_DIV0_DETECT_EN defined, DIV with b=0 sampled at E0 SHALL go directly to DONE: done=1, div0=1 for the cycle after E0, hi/lo unchanged, then return to IDLE.
REQ-018 Without MULDIV_DIV0_DETECT_EN, DIV with b=0 SHALL run the normal 33-cycle sequence with div0 held at 0.
REQ-019 In that case the result SHALL be lo=0xFFFFFFFF (a>=0) or lo=0x00000001 (a<0), and hi=a.

Verification
REQ-020 MULT, a=3, b=0xFFFFFFFB -> done at E33, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy high over E0..E34.
REQ-021 MULT, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-022 DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-023 DIV, a=7, b=0 with the macro defined -> done=div0=1 one cycle after E0, hi/lo keep prior values.
REQ-024 DIV, a=7, b=0 without the macro -> done at E33, div0=0, lo=0xFFFFFFFF, hi=7.
REQ-025 start pulsed at E10 during a MULT -> ignored and the result is unchanged; reset=0 at E20 of a DIV -> hi=lo=0, busy=0 immediately, and the next start completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequential 32x32 signed multiply / restoring divide with HI/LO results.
// Define MULDIV_DIV0_DETECT_EN to short-circuit DIV by zero with a div0 flag.
module muldiv_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic [31:0] hi_acc_q, hi_acc_d;
  logic [31:0] lo_acc_q, lo_acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] sum;
  logic [32:0] rem_s;
  logic [32:0] diff;
  logic        no_borrow;
  logic [63:0] prod;
  logic [63:0] prod_n;

  assign abs_a = a[31] ? -a : a;
  assign abs_b = b[31] ? -b : b;

  // Multiply: add multiplicand on LSB of {hi,lo}, then shift right.
  assign sum = {1'b0, hi_acc_q}
             + (lo_acc_q[0] ? {1'b0, ma_q} : 33'd0);

  // Divide: shift {rem,quo} left, trial-subtract the divisor.
  assign rem_s     = {hi_acc_q, lo_acc_q[31]};
  assign diff      = rem_s - {1'b0, mb_q};
  assign no_borrow = ~diff[32];

  assign prod   = {hi_acc_q, lo_acc_q};
  assign prod_n = -prod;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    hi_acc_d = hi_acc_q;
    lo_acc_d = lo_acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          sa_d     = a[31];
          sb_d     = b[31];
          ma_d     = abs_a;
          mb_d     = abs_b;
          hi_acc_d = 32'd0;
          lo_acc_d = op ? abs_a : abs_b;
          cnt_d    = 6'd0;
          busy_d   = 1'b1;
          state_d  = CALC;
`ifdef MULDIV_DIV0_DETECT_EN
          if (op && (b == 32'd0)) begin
            done_d  = 1'b1;
            div0_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (op_q) begin
          hi_acc_d = no_borrow ? diff[31:0] : rem_s[31:0];
          lo_acc_d = {lo_acc_q[30:0], no_borrow};
        end else begin
          hi_acc_d = sum[32:1];
          lo_acc_d = {sum[0], lo_acc_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (op_q) begin
          lo_d = (sa_q ^ sb_q) ? -lo_acc_q : lo_acc_q;
          hi_d = sa_q ? -hi_acc_q : hi_acc_q;
        end else if (sa_q ^ sb_q) begin
          hi_d = prod_n[63:32];
          lo_d = prod_n[31:0];
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        div0_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        div0_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      hi_acc_q <= 32'd0;
      lo_acc_q <= 32'd0;
      cnt_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      hi_acc_q <= hi_acc_d;
      lo_acc_q <= lo_acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic reference.
// Follows MULDIV_DIV0_DETECT_EN the same way the design does.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  muldiv_sequencer dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  task automatic model(input bit o,
                       input logic [31:0] va,
                       input logic [31:0] vb,
                       output logic [31:0] eh,
                       output logic [31:0] el,
                       output bit ed,
                       output int lat);
    longint sa, sb, p, q, r;
    sa  = longint'($signed(va));
    sb  = longint'($signed(vb));
    ed  = 1'b0;
    lat = 33;
    if (!o) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (vb == 32'd0) begin
`ifdef MULDIV_DIV0_DETECT_EN
      eh  = prev_hi;
      el  = prev_lo;
      ed  = 1'b1;
      lat = 0;
`else
      eh = va;
      el = va[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endtask

  task automatic run_op(input bit o,
                        input logic [31:0] va,
                        input logic [31:0] vb,
                        input int poke);
    logic [31:0] eh, el;
    bit ed, busy_ok, held_ok;
    int lat, edges;
    model(o, va, vb, eh, el, ed, lat);
    @(negedge clock);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 0; busy_ok = 1'b1; held_ok = 1'b1;
    while (!done && edges < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
      if (poke != 0 && edges == poke) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      edges++;
    end
    start = 1'b0;
    chk("latency", edges, lat);
    chk("busy_at_done", busy, 1);
    chk("busy_during", busy_ok, 1);
    chk("hilo_held", held_ok, 1);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div0", div0, ed);
    @(posedge clock); #1;
    chk("done_pulse", done, 0);
    chk("busy_clear", busy, 0);
    chk("div0_clear", div0, 0);
    chk("hi_hold", hi, eh);
    chk("lo_hold", lo, el);
    prev_hi = eh;
    prev_lo = el;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 20)) - 32'd10;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;

    run_op(1'b0, 32'd3, 32'hFFFF_FFFB, 0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 32'd7, 32'd0, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 0);
    run_op(1'b0, 32'd0, 32'h1234_5678, 0);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 9);

    // Abort a DIV mid-way with reset.
    @(negedge clock);
    op = 1'b1; a = 32'h7654_3210; b = 32'd13; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_div0", div0, 0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    run_op(1'b1, 32'h7654_3210, 32'd13, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), rnd_val(), rnd_val(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
